// File: rtl/sensor_seq_ctrl.sv
// Sequencer for a VCO-based temperature sensor. It holds the sensor in reset,
// opens a counting window, then shifts the captured count out MSB-first.
// Optional SENSOR_SEQ_CTRL_AVG_EN: average four back-to-back passes per start_i.
module sensor_seq_ctrl #(
    parameter int DATA_W     = 16,
    parameter int SHIFT_HALF = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              start_i,
    input  logic [7:0]        rst_len_i,
    input  logic [15:0]       gate_len_i,
    input  logic              sr_in_i,
    input  logic              irq_clr_i,
    output logic              sens_rst_o,
    output logic              shift_clk_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              irq_o
);

    localparam int BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [3:0]       PH_LAST  = 4'(SHIFT_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_GATE  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_sens_rst;
    logic               r_shclk;
    logic               r_busy;
    logic               r_done;
    logic               r_irq;
    logic [DATA_W-1:0]  r_result;
    logic [DATA_W-1:0]  r_shreg;
    logic [15:0]        r_cnt;
    logic [15:0]        r_gate_len;
    logic [3:0]         r_phase;
    logic [BIT_W-1:0]   r_bit;

    logic [7:0]         w_rst_eff;
    logic [15:0]        w_gate_eff;

`ifdef SENSOR_SEQ_CTRL_AVG_EN
    logic [1:0]         r_pass;
    logic [7:0]         r_rst_len;
    logic [DATA_W+1:0]  r_sum;
    logic [DATA_W+1:0]  w_sum_next;

    assign w_sum_next = r_sum + {2'b00, r_shreg};
`endif

    assign w_rst_eff  = (rst_len_i == 8'd0)   ? 8'd1  : rst_len_i;
    assign w_gate_eff = (gate_len_i == 16'd0) ? 16'd1 : gate_len_i;

    assign sens_rst_o  = r_sens_rst;
    assign shift_clk_o = r_shclk;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign result_o    = r_result;
    assign irq_o       = r_irq;

    // Counters hold (length - 1) and count down, so a 16-bit gate length of 65535 never wraps.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state    <= ST_IDLE;
            r_sens_rst <= 1'b1;
            r_shclk    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_irq      <= 1'b0;
            r_result   <= '0;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_gate_len <= '0;
            r_phase    <= '0;
            r_bit      <= '0;
`ifdef SENSOR_SEQ_CTRL_AVG_EN
            r_pass     <= '0;
            r_rst_len  <= '0;
            r_sum      <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            // Holding the set through the DONE cycle makes set win over a same-cycle clear.
            if (r_state == ST_DONE) begin
                r_irq <= 1'b1;
            end else if (irq_clr_i) begin
                r_irq <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state    <= ST_RESET;
                        r_busy     <= 1'b1;
                        r_sens_rst <= 1'b1;
                        r_gate_len <= w_gate_eff;
                        r_cnt      <= {8'd0, w_rst_eff} - 16'd1;
`ifdef SENSOR_SEQ_CTRL_AVG_EN
                        r_rst_len  <= w_rst_eff;
                        r_pass     <= 2'd0;
                        r_sum      <= '0;
`endif
                    end
                end

                ST_RESET: begin
                    if (r_cnt == 16'd0) begin
                        r_state    <= ST_GATE;
                        r_sens_rst <= 1'b0;
                        r_cnt      <= r_gate_len - 16'd1;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end

                ST_GATE: begin
                    if (r_cnt == 16'd0) begin
                        r_state <= ST_SHIFT;
                        r_shclk <= 1'b1;
                        r_phase <= '0;
                        r_bit   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end

                ST_SHIFT: begin
                    if (r_phase == PH_LAST) begin
                        r_phase <= '0;
                        if (r_shclk) begin
                            r_shreg <= {r_shreg[DATA_W-2:0], sr_in_i};
                            r_shclk <= 1'b0;
                        end else if (r_bit == BIT_LAST) begin
`ifdef SENSOR_SEQ_CTRL_AVG_EN
                            r_sens_rst <= 1'b1;
                            if (r_pass == 2'd3) begin
                                r_state  <= ST_DONE;
                                r_done   <= 1'b1;
                                r_irq    <= 1'b1;
                                r_result <= w_sum_next[DATA_W+1:2];
                            end else begin
                                r_state <= ST_RESET;
                                r_pass  <= r_pass + 2'd1;
                                r_sum   <= w_sum_next;
                                r_cnt   <= {8'd0, r_rst_len} - 16'd1;
                            end
`else
                            r_state    <= ST_DONE;
                            r_sens_rst <= 1'b1;
                            r_done     <= 1'b1;
                            r_irq      <= 1'b1;
                            r_result   <= r_shreg;
`endif
                        end else begin
                            r_bit   <= r_bit + BIT_W'(1);
                            r_shclk <= 1'b1;
                        end
                    end else begin
                        r_phase <= r_phase + 4'd1;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_sens_rst <= 1'b1;
                    r_shclk    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_seq_ctrl.sv
// Directed self-checking bench for sensor_seq_ctrl: timing, serial capture,
// busy/irq behaviour and asynchronous reset, with hand-computed expectations.
module tb_sensor_seq_ctrl;

    localparam int DW = 16;
    localparam int SH = 2;

    logic          wb_clk_i;
    logic          wb_rst_ni;
    logic          start_i;
    logic [7:0]    rst_len_i;
    logic [15:0]   gate_len_i;
    logic          sr_in_i;
    logic          irq_clr_i;
    logic          sens_rst_o;
    logic          shift_clk_o;
    logic          busy_o;
    logic          done_o;
    logic [DW-1:0] result_o;
    logic          irq_o;

    int passCount;
    int totalCount;

    sensor_seq_ctrl #(.DATA_W(DW), .SHIFT_HALF(SH)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_ni  (wb_rst_ni),
        .start_i    (start_i),
        .rst_len_i  (rst_len_i),
        .gate_len_i (gate_len_i),
        .sr_in_i    (sr_in_i),
        .irq_clr_i  (irq_clr_i),
        .sens_rst_o (sens_rst_o),
        .shift_clk_o(shift_clk_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .irq_o      (irq_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // Starts a measurement and runs it cycle by cycle, sampling on falling edges.
    // Cycle 0 is the cycle after the edge that captures start_i.
    task automatic measure(input logic [7:0] rl, input logic [15:0] gl,
                           input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3,
                           input int restartCyc, input int clrCyc, input int rstCyc,
                           input int limit,
                           output int doneCyc, output int doneCnt,
                           output int lowBad, output int highBad, output int rises);
        int r, g, p, k, idx;
        logic [15:0] w;
        logic prevClk;
        r = (rl == 8'd0) ? 1 : int'(rl);
        g = (gl == 16'd0) ? 1 : int'(gl);
        p = r + g + 2 * SH * DW;
        doneCyc = -1; doneCnt = 0; lowBad = 0; highBad = 0; rises = 0; prevClk = 1'b0;
        @(negedge wb_clk_i);
        rst_len_i = rl; gate_len_i = gl; start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (done_o === 1'b1) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = c;
            end
            if (c >= r + 1 && c <= r + g + 2 * SH * DW - 1 && sens_rst_o !== 1'b0) lowBad++;
            if (c < r && sens_rst_o !== 1'b1) highBad++;
            if (c < p && shift_clk_o === 1'b1 && !prevClk) rises++;
            prevClk = (shift_clk_o === 1'b1);
            k = c % p;
            if (k >= r + g) begin
                idx = (k - r - g) / (2 * SH);
                case (c / p)
                    0: w = w0;
                    1: w = w1;
                    2: w = w2;
                    default: w = w3;
                endcase
                sr_in_i = w[15 - idx];
            end else begin
                sr_in_i = 1'b0;
            end
            start_i   = (c == restartCyc);
            irq_clr_i = (c == clrCyc);
            if (c == rstCyc) begin
                wb_rst_ni = 1'b0;
                #1;
                return;
            end
            @(negedge wb_clk_i);
        end
        start_i = 1'b0; irq_clr_i = 1'b0; sr_in_i = 1'b0;
    endtask

    task automatic test_reset();
        totalCount++; if (sens_rst_o !== 1'b1) $display("[TB] FAIL reset_sens_rst got %b want 1", sens_rst_o); else passCount++;
        totalCount++; if (shift_clk_o !== 1'b0) $display("[TB] FAIL reset_shift_clk got %b want 0", shift_clk_o); else passCount++;
        totalCount++; if (busy_o !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy_o); else passCount++;
        totalCount++; if (done_o !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", done_o); else passCount++;
        totalCount++; if (irq_o !== 1'b0) $display("[TB] FAIL reset_irq got %b want 0", irq_o); else passCount++;
        totalCount++; if (result_o !== 16'h0000) $display("[TB] FAIL reset_result got %h want 0000", result_o); else passCount++;
    endtask

    task automatic test_single();
        int dc, dn, lb, hb, rs;
        measure(8'd4, 16'd100, 16'hA5C3, 16'h0, 16'h0, 16'h0, -1, -1, -1, 200, dc, dn, lb, hb, rs);
        totalCount++; if (dc !== 168) $display("[TB] FAIL single_done_cycle got %0d want 168", dc); else passCount++;
        totalCount++; if (dn !== 1) $display("[TB] FAIL single_done_count got %0d want 1", dn); else passCount++;
        totalCount++; if (result_o !== 16'hA5C3) $display("[TB] FAIL single_result got %h want a5c3", result_o); else passCount++;
        totalCount++; if (irq_o !== 1'b1) $display("[TB] FAIL single_irq got %b want 1", irq_o); else passCount++;
        totalCount++; if (lb !== 0) $display("[TB] FAIL single_sens_rst_low bad cycles %0d want 0", lb); else passCount++;
        totalCount++; if (hb !== 0) $display("[TB] FAIL single_sens_rst_high bad cycles %0d want 0", hb); else passCount++;
        totalCount++; if (rs !== 16) $display("[TB] FAIL single_shift_pulses got %0d want 16", rs); else passCount++;
        totalCount++; if (busy_o !== 1'b0) $display("[TB] FAIL single_busy_after got %b want 0", busy_o); else passCount++;
    endtask

    task automatic test_zero_len();
        int dc, dn, lb, hb, rs;
        measure(8'd0, 16'd0, 16'h1234, 16'h0, 16'h0, 16'h0, -1, -1, -1, 100, dc, dn, lb, hb, rs);
        totalCount++; if (dc !== 66) $display("[TB] FAIL zero_len_done_cycle got %0d want 66", dc); else passCount++;
        totalCount++; if (result_o !== 16'h1234) $display("[TB] FAIL zero_len_result got %h want 1234", result_o); else passCount++;
        totalCount++; if (rs !== 16) $display("[TB] FAIL zero_len_shift_pulses got %0d want 16", rs); else passCount++;
    endtask

    task automatic test_busy_irq();
        int dc, dn, lb, hb, rs;
        @(negedge wb_clk_i); irq_clr_i = 1'b1;
        @(negedge wb_clk_i); irq_clr_i = 1'b0;
        totalCount++; if (irq_o !== 1'b0) $display("[TB] FAIL irq_clear_pre got %b want 0", irq_o); else passCount++;
        measure(8'd4, 16'd100, 16'h5A0F, 16'h0, 16'h0, 16'h0, 50, 168, -1, 400, dc, dn, lb, hb, rs);
        totalCount++; if (dn !== 1) $display("[TB] FAIL busy_done_count got %0d want 1", dn); else passCount++;
        totalCount++; if (dc !== 168) $display("[TB] FAIL busy_done_cycle got %0d want 168", dc); else passCount++;
        totalCount++; if (result_o !== 16'h5A0F) $display("[TB] FAIL busy_result got %h want 5a0f", result_o); else passCount++;
        totalCount++; if (irq_o !== 1'b1) $display("[TB] FAIL irq_set_wins got %b want 1", irq_o); else passCount++;
        @(negedge wb_clk_i); irq_clr_i = 1'b1;
        @(negedge wb_clk_i); irq_clr_i = 1'b0;
        totalCount++; if (irq_o !== 1'b0) $display("[TB] FAIL irq_clear_post got %b want 0", irq_o); else passCount++;
    endtask

    task automatic test_reset_mid();
        int dc, dn, lb, hb, rs;
        // Leave irq set from a completed run so that reset is seen to clear it.
        measure(8'd1, 16'd1, 16'h00FF, 16'h0, 16'h0, 16'h0, -1, -1, -1, 80, dc, dn, lb, hb, rs);
        measure(8'd4, 16'd100, 16'hFFFF, 16'h0, 16'h0, 16'h0, -1, -1, 130, 200, dc, dn, lb, hb, rs);
        totalCount++; if (sens_rst_o !== 1'b1) $display("[TB] FAIL midrst_sens_rst got %b want 1", sens_rst_o); else passCount++;
        totalCount++; if (shift_clk_o !== 1'b0) $display("[TB] FAIL midrst_shift_clk got %b want 0", shift_clk_o); else passCount++;
        totalCount++; if (busy_o !== 1'b0) $display("[TB] FAIL midrst_busy got %b want 0", busy_o); else passCount++;
        totalCount++; if (irq_o !== 1'b0) $display("[TB] FAIL midrst_irq got %b want 0", irq_o); else passCount++;
        totalCount++; if (result_o !== 16'h0000) $display("[TB] FAIL midrst_result got %h want 0000", result_o); else passCount++;
        totalCount++; if (dn !== 0) $display("[TB] FAIL midrst_no_done got %0d want 0", dn); else passCount++;
        repeat (3) @(negedge wb_clk_i);
        totalCount++; if (done_o !== 1'b0) $display("[TB] FAIL midrst_done_held got %b want 0", done_o); else passCount++;
        wb_rst_ni = 1'b1;
        measure(8'd4, 16'd100, 16'hC3A5, 16'h0, 16'h0, 16'h0, -1, -1, -1, 200, dc, dn, lb, hb, rs);
        totalCount++; if (dc !== 168) $display("[TB] FAIL fresh_done_cycle got %0d want 168", dc); else passCount++;
        totalCount++; if (result_o !== 16'hC3A5) $display("[TB] FAIL fresh_result got %h want c3a5", result_o); else passCount++;
    endtask

`ifdef SENSOR_SEQ_CTRL_AVG_EN
    task automatic test_avg();
        int dc, dn, lb, hb, rs;
        measure(8'd4, 16'd100, 16'd100, 16'd101, 16'd102, 16'd104, -1, -1, -1, 720, dc, dn, lb, hb, rs);
        totalCount++; if (dc !== 672) $display("[TB] FAIL avg_done_cycle got %0d want 672", dc); else passCount++;
        totalCount++; if (dn !== 1) $display("[TB] FAIL avg_done_count got %0d want 1", dn); else passCount++;
        totalCount++; if (result_o !== 16'd101) $display("[TB] FAIL avg_result got %0d want 101", result_o); else passCount++;
    endtask
`endif

    initial begin
        passCount = 0;
        totalCount = 0;
        wb_rst_ni = 1'b0;
        start_i = 1'b0;
        rst_len_i = 8'd0;
        gate_len_i = 16'd0;
        sr_in_i = 1'b0;
        irq_clr_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        test_reset();
        wb_rst_ni = 1'b1;
        test_single();
        test_zero_len();
        test_busy_irq();
        test_reset_mid();
`ifdef SENSOR_SEQ_CTRL_AVG_EN
        test_avg();
`endif
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
